// File: rtl/camerica_pkg.sv
// Shared types and mapper-number constants for the Camerica/discrete-latch mapper.
package camerica_pkg;

  typedef enum logic [1:0] {M2, M71, M232} mode_e;
  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_e;

  localparam logic [7:0] MAPPER_UXROM    = 8'd2;
  localparam logic [7:0] MAPPER_CAMERICA = 8'd71;
  localparam logic [7:0] MAPPER_QUATTRO  = 8'd232;

  // Unknown mapper numbers fall back to plain UxROM behaviour.
  function automatic mode_e decode_mode(input logic [7:0] num);
    if (num == MAPPER_QUATTRO)       return M232;
    else if (num == MAPPER_CAMERICA) return M71;
    else                             return M2;
  endfunction

endpackage

// File: rtl/camerica_conflict_fetch.sv
// Write capture and optional bus-conflict fetch: turns an accepted CPU write into a
// commit pulse carrying the effective (optionally ROM-ANDed) data.
module camerica_conflict_fetch
  import camerica_pkg::*;
#(
  parameter int BUS_CONFLICT = 1,
  parameter int TIMEOUT      = 15
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wr_accept,
  input  logic [1:0]  i_wr_sel,
  input  logic [7:0]  i_din,
  input  logic [21:0] i_addr,
  input  logic        i_cfl_ack,
  input  logic [7:0]  i_cfl_data,
  output logic        o_cfl_req,
  output logic [21:0] o_cfl_addr,
  output logic        o_busy,
  output logic        o_wr_drop,
  output logic        o_commit,
  output logic [1:0]  o_commit_sel,
  output logic [7:0]  o_commit_data
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  generate
    if (BUS_CONFLICT != 0) begin : g_conflict
      state_e          r_state;
      logic [CW-1:0]   r_cnt;
      logic            r_req;
      logic            r_busy;
      logic            r_wr_drop;
      logic [1:0]      r_sel;
      logic [7:0]      r_din;
      logic [7:0]      r_eff;
      logic [21:0]     r_addr;

      // An ack that coincides with the timeout takes priority, so the merged value wins.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_req     <= 1'b0;
          r_busy    <= 1'b0;
          r_wr_drop <= 1'b0;
          r_sel     <= '0;
          r_din     <= '0;
          r_eff     <= '0;
          r_addr    <= '0;
        end else begin
          r_wr_drop <= i_wr_accept && (r_state != IDLE);
          case (r_state)
            IDLE: begin
              if (i_wr_accept) begin
                r_state <= FETCH;
                r_req   <= 1'b1;
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_sel   <= i_wr_sel;
                r_din   <= i_din;
                r_addr  <= i_addr;
              end
            end
            FETCH: begin
              if (i_cfl_ack) begin
                r_state <= COMMIT;
                r_req   <= 1'b0;
                r_eff   <= r_din & i_cfl_data;
              end else if (r_cnt == CW'(TIMEOUT)) begin
                r_state <= COMMIT;
                r_req   <= 1'b0;
                r_eff   <= r_din;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            COMMIT: begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end
            default: r_state <= IDLE;
          endcase
        end
      end

      assign o_cfl_req     = r_req;
      assign o_cfl_addr    = r_addr;
      assign o_busy        = r_busy;
      assign o_wr_drop     = r_wr_drop;
      assign o_commit      = (r_state == COMMIT);
      assign o_commit_sel  = r_sel;
      assign o_commit_data = r_eff;
    end else begin : g_direct
      logic w_unused;
      assign w_unused      = ^{i_clk, i_reset_n, i_addr, i_cfl_ack, i_cfl_data};
      assign o_cfl_req     = 1'b0;
      assign o_cfl_addr    = '0;
      assign o_busy        = 1'b0;
      assign o_wr_drop     = 1'b0;
      assign o_commit      = i_wr_accept;
      assign o_commit_sel  = i_wr_sel;
      assign o_commit_data = i_din;
    end
  endgenerate

endmodule

// File: rtl/camerica_latch_mapper.sv
// Camerica/discrete-latch mapper (iNES 71, 232, 2): bank registers, PRG/CHR address
// generation and nametable selection.
module camerica_latch_mapper
  import camerica_pkg::*;
#(
  parameter int         PRG_BITS     = 8,
  parameter int         BUS_CONFLICT = 1,
  parameter int         TIMEOUT      = 15,
  parameter logic [8:0] CHR_BASE     = 9'h100
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_ce,
  input  logic [31:0]         i_flags,
  input  logic [PRG_BITS-1:0] i_prg_bank_mask,
  input  logic [15:0]         i_prg_ain,
  input  logic                i_prg_read,
  input  logic                i_prg_write,
  input  logic [7:0]          i_prg_din,
  output logic [21:0]         o_prg_aout,
  output logic                o_prg_allow,
  input  logic [13:0]         i_chr_ain,
  output logic [21:0]         o_chr_aout,
  output logic                o_chr_allow,
  output logic                o_vram_a10,
  output logic                o_vram_ce,
  output logic                o_cfl_req,
  output logic [21:0]         o_cfl_addr,
  input  logic                i_cfl_ack,
  input  logic [7:0]          i_cfl_data,
  output logic                o_busy,
  output logic                o_wr_drop
);

  localparam logic [7:0] LOW_MASK = 8'((1 << PRG_BITS) - 1);

  logic [7:0]          r_inner;
  logic [1:0]          r_outer;
  logic                r_ciram_sel;
  mode_e               w_mode;
  logic                w_wr_accept;
  logic                w_commit;
  logic [1:0]          w_commit_sel;
  logic [7:0]          w_commit_data;
  logic [7:0]          w_bank8;
  logic [PRG_BITS-1:0] w_bank;
  logic                w_unused;

  assign w_mode      = decode_mode(i_flags[7:0]);
  assign w_wr_accept = i_ce && i_prg_write && i_prg_ain[15];
  assign w_unused    = ^{i_prg_read, i_flags[31:16], i_flags[13:8], w_bank8};

  camerica_conflict_fetch #(
    .BUS_CONFLICT (BUS_CONFLICT),
    .TIMEOUT      (TIMEOUT)
  ) u_fetch (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_wr_accept   (w_wr_accept),
    .i_wr_sel      (i_prg_ain[14:13]),
    .i_din         (i_prg_din),
    .i_addr        (o_prg_aout),
    .i_cfl_ack     (i_cfl_ack),
    .i_cfl_data    (i_cfl_data),
    .o_cfl_req     (o_cfl_req),
    .o_cfl_addr    (o_cfl_addr),
    .o_busy        (o_busy),
    .o_wr_drop     (o_wr_drop),
    .o_commit      (w_commit),
    .o_commit_sel  (w_commit_sel),
    .o_commit_data (w_commit_data)
  );

  // Inner is kept 8 bits wide so the Quattro 2-bit update works for any PRG_BITS.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_inner     <= '0;
      r_outer     <= '0;
      r_ciram_sel <= 1'b0;
    end else if (w_commit) begin
      case (w_mode)
        M232: begin
          if (!w_commit_sel[1]) r_outer <= w_commit_data[4:3];
          else                  r_inner[1:0] <= w_commit_data[1:0];
        end
        M71: begin
          if (w_commit_sel[1])       r_inner <= w_commit_data & LOW_MASK;
          else if (!w_commit_sel[0]) r_ciram_sel <= w_commit_data[4];
        end
        default: r_inner <= w_commit_data & LOW_MASK;
      endcase
    end
  end

  always_comb begin
    w_bank8 = 8'hFF;
    if (!i_prg_ain[14]) w_bank8 = (w_mode == M232) ? {4'b0, r_outer, r_inner[1:0]} : r_inner;
    else if (w_mode == M232) w_bank8 = {4'b0, r_outer, 2'b11};
  end

  assign w_bank      = w_bank8[PRG_BITS-1:0] & i_prg_bank_mask;
  assign o_prg_aout  = {8'(w_bank), i_prg_ain[13:0]};
  assign o_prg_allow = i_prg_ain[15] && !i_prg_write;
  assign o_chr_aout  = {CHR_BASE, i_chr_ain[12:0]};
  assign o_chr_allow = i_flags[15];
  assign o_vram_a10  = i_flags[14] ? i_chr_ain[10] : r_ciram_sel;
  assign o_vram_ce   = i_chr_ain[13];

endmodule

// File: tb/tb_camerica_latch_mapper.sv
// Directed bench: one direct-commit instance and one bus-conflict instance, checked
// through an expected-value queue with immediate assertions.
module tb_camerica_latch_mapper;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [31:0] flags;
  logic [7:0]  mask;
  logic [15:0] prg_ain;
  logic        prg_read;
  logic        wr0;
  logic        wr1;
  logic [7:0]  din;
  logic [13:0] chr_ain;
  logic        cfl_ack;
  logic [7:0]  cfl_data;

  logic [21:0] aout0, aout1, chr_aout0, chr_aout1, cfl_addr0, cfl_addr1;
  logic        allow0, allow1, chr_allow0, chr_allow1, a10_0, a10_1, vce0, vce1;
  logic        req0, req1, busy0, busy1, drop0, drop1;

  exp_t sb[$];
  int   checkCount = 0;
  int   errorCount = 0;
  int   reqCycles;

  camerica_latch_mapper #(.PRG_BITS(8), .BUS_CONFLICT(0), .TIMEOUT(15), .CHR_BASE(9'h100)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_flags(flags), .i_prg_bank_mask(mask),
    .i_prg_ain(prg_ain), .i_prg_read(prg_read), .i_prg_write(wr0), .i_prg_din(din),
    .o_prg_aout(aout0), .o_prg_allow(allow0), .i_chr_ain(chr_ain), .o_chr_aout(chr_aout0),
    .o_chr_allow(chr_allow0), .o_vram_a10(a10_0), .o_vram_ce(vce0), .o_cfl_req(req0),
    .o_cfl_addr(cfl_addr0), .i_cfl_ack(cfl_ack), .i_cfl_data(cfl_data), .o_busy(busy0),
    .o_wr_drop(drop0)
  );

  camerica_latch_mapper #(.PRG_BITS(8), .BUS_CONFLICT(1), .TIMEOUT(15), .CHR_BASE(9'h100)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_flags(flags), .i_prg_bank_mask(mask),
    .i_prg_ain(prg_ain), .i_prg_read(prg_read), .i_prg_write(wr1), .i_prg_din(din),
    .o_prg_aout(aout1), .o_prg_allow(allow1), .i_chr_ain(chr_ain), .o_chr_aout(chr_aout1),
    .o_chr_allow(chr_allow1), .o_vram_a10(a10_1), .o_vram_ce(vce1), .o_cfl_req(req1),
    .o_cfl_addr(cfl_addr1), .i_cfl_ack(cfl_ack), .i_cfl_data(cfl_data), .o_busy(busy1),
    .o_wr_drop(drop1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expectVal(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    checkCount++;
    if (sb.size() == 0) begin
      errorCount++;
      $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.val) else begin
        errorCount++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.val);
      end
    end
  endtask

  // One CPU write to the selected instance; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input int dutSel, input logic [15:0] addr, input logic [7:0] data);
    prg_ain = addr;
    din     = data;
    if (dutSel == 0) wr0 = 1'b1;
    else             wr1 = 1'b1;
    @(posedge clk);
    #1;
    wr0 = 1'b0;
    wr1 = 1'b0;
  endtask

  task automatic readAddr(input logic [15:0] addr);
    prg_ain = addr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; flags = 32'h47; mask = 8'h0F; prg_ain = 16'h8000;
    prg_read = 1'b0; wr0 = 1'b0; wr1 = 1'b0; din = 8'h00; chr_ain = 14'h0000;
    cfl_ack = 1'b0; cfl_data = 8'h00;
    #12;

    $display("[TB] reset state");
    expectVal("reset_aout_8000", 32'h0);     checkOutput(32'(aout0));
    readAddr(16'hC000);
    expectVal("reset_aout_C000", 32'h3C000); checkOutput(32'(aout0));
    expectVal("reset_busy", 32'h0);          checkOutput(32'(busy1));
    expectVal("reset_req", 32'h0);           checkOutput(32'(req1));
    expectVal("reset_drop", 32'h0);          checkOutput(32'(drop1));
    expectVal("reset_a10", 32'h0);           checkOutput(32'(a10_0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] M71 direct commit");
    applyStimulus(0, 16'hC000, 8'h05);
    readAddr(16'h8000);
    expectVal("m71_8000", 32'h14000);        checkOutput(32'(aout0));
    expectVal("prg_allow", 32'h1);           checkOutput(32'(allow0));
    readAddr(16'hC000);
    expectVal("m71_C000", 32'h3C000);        checkOutput(32'(aout0));
    chr_ain = 14'h1ABC; #1;
    expectVal("chr_aout_lo", 32'h201ABC);    checkOutput(32'(chr_aout0));
    expectVal("vram_ce_lo", 32'h0);          checkOutput(32'(vce0));
    chr_ain = 14'h2ABC; #1;
    expectVal("chr_aout_hi", 32'h200ABC);    checkOutput(32'(chr_aout0));
    expectVal("vram_ce_hi", 32'h1);          checkOutput(32'(vce0));
    flags = 32'h8047; #1;
    expectVal("chr_allow", 32'h1);           checkOutput(32'(chr_allow0));
    flags = 32'h47;

    $display("[TB] M71 mirroring");
    applyStimulus(0, 16'h9000, 8'h10);
    expectVal("ciram_set", 32'h1);           checkOutput(32'(a10_0));
    applyStimulus(0, 16'hA000, 8'h00);
    expectVal("ciram_keep", 32'h1);          checkOutput(32'(a10_0));
    readAddr(16'h8000);
    expectVal("a000_no_bank", 32'h14000);    checkOutput(32'(aout0));
    flags = 32'h4047; chr_ain = 14'h0000; #1;
    expectVal("hard_mirror_0", 32'h0);       checkOutput(32'(a10_0));
    chr_ain = 14'h0400; #1;
    expectVal("hard_mirror_1", 32'h1);       checkOutput(32'(a10_0));
    flags = 32'h47;

    $display("[TB] M232 and M2");
    flags = 32'd232; mask = 8'hFF;
    applyStimulus(0, 16'h8000, 8'h18);
    applyStimulus(0, 16'hC000, 8'h02);
    readAddr(16'h8000);
    expectVal("m232_8000", 32'h38000);       checkOutput(32'(aout0));
    readAddr(16'hC000);
    expectVal("m232_C000", 32'h3C000);       checkOutput(32'(aout0));
    flags = 32'd2;
    applyStimulus(0, 16'h8000, 8'h07);
    readAddr(16'h8000);
    expectVal("m2_8000", 32'h1C000);         checkOutput(32'(aout0));
    readAddr(16'hC000);
    expectVal("m2_C000", 32'h3FC000);        checkOutput(32'(aout0));
    mask = 8'h03; readAddr(16'h8000);
    expectVal("m2_masked", 32'h0C000);       checkOutput(32'(aout0));

    $display("[TB] conflict fetch with ack");
    flags = 32'h47; mask = 8'h0F;
    applyStimulus(1, 16'hC000, 8'h3E);
    expectVal("fetch_req", 32'h1);           checkOutput(32'(req1));
    expectVal("fetch_busy", 32'h1);          checkOutput(32'(busy1));
    expectVal("fetch_addr", 32'h3C000);      checkOutput(32'(cfl_addr1));
    tick();
    tick();
    cfl_ack = 1'b1; cfl_data = 8'h27;
    tick();
    cfl_ack = 1'b0;
    expectVal("commit_req_low", 32'h0);      checkOutput(32'(req1));
    expectVal("commit_busy", 32'h1);         checkOutput(32'(busy1));
    tick();
    expectVal("ack_idle", 32'h0);            checkOutput(32'(busy1));
    readAddr(16'h8000);
    expectVal("ack_and_bank", 32'h18000);    checkOutput(32'(aout1));
    cfl_ack = 1'b1;
    tick();
    cfl_ack = 1'b0;
    expectVal("stray_ack_busy", 32'h0);      checkOutput(32'(busy1));
    expectVal("stray_ack_req", 32'h0);       checkOutput(32'(req1));

    $display("[TB] conflict fetch timeout and drop");
    applyStimulus(1, 16'hC000, 8'h09);
    reqCycles = 0;
    if (req1) reqCycles++;
    prg_ain = 16'h9000; din = 8'h10; wr1 = 1'b1;
    tick();
    wr1 = 1'b0;
    expectVal("wr_drop_pulse", 32'h1);       checkOutput(32'(drop1));
    if (req1) reqCycles++;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!req1) break;
      reqCycles++;
    end
    expectVal("req_cycles", 32'd16);         checkOutput(32'(reqCycles));
    expectVal("wr_drop_clear", 32'h0);       checkOutput(32'(drop1));
    tick();
    expectVal("timeout_idle", 32'h0);        checkOutput(32'(busy1));
    expectVal("drop_no_ciram", 32'h0);       checkOutput(32'(a10_1));
    readAddr(16'h8000);
    expectVal("timeout_raw", 32'h24000);     checkOutput(32'(aout1));

    $display("[TB] reset mid fetch");
    applyStimulus(1, 16'hC000, 8'h0A);
    expectVal("pre_reset_req", 32'h1);       checkOutput(32'(req1));
    #2 rst_n = 1'b0;
    #1;
    expectVal("areset_req", 32'h0);          checkOutput(32'(req1));
    expectVal("areset_busy", 32'h0);         checkOutput(32'(busy1));
    readAddr(16'h8000);
    expectVal("areset_bank1", 32'h0);        checkOutput(32'(aout1));
    expectVal("areset_bank0", 32'h0);        checkOutput(32'(aout0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
